// File: rtl/bcd_serial_converter.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// Signed/unsigned operand, sticky overflow when the magnitude exceeds DIGITS digits.
module bcd_serial_converter #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  signed_mode,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg,
    output logic                  ovf
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] BIN_ONE  = WIDTH'(1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                state_reg, state_next;
    logic [WIDTH-1:0]      mag_reg, mag_next;
    logic [4*DIGITS-1:0]   digits_reg, digits_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic                  neg_int_reg, neg_int_next;
    logic                  ovf_int_reg, ovf_int_next;
    logic [4*DIGITS-1:0]   bcd_reg, bcd_next;
    logic                  neg_reg, neg_next;
    logic                  ovf_reg, ovf_next;
    logic                  done_reg, done_next;

    logic [4*DIGITS-1:0]   adj;
    logic [4*DIGITS-1:0]   shifted;
    logic                  carry_out;

    // Per-digit add-3 correction; digits never carry into each other here.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign adj[4*gi+3 -: 4] = (digits_reg[4*gi+3 -: 4] >= 4'd5)
                                    ? digits_reg[4*gi+3 -: 4] + 4'd3
                                    : digits_reg[4*gi+3 -: 4];
        end
    endgenerate

    assign shifted   = {adj[4*DIGITS-2:0], mag_reg[WIDTH-1]};
    assign carry_out = adj[4*DIGITS-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            mag_reg     <= '0;
            digits_reg  <= '0;
            cnt_reg     <= '0;
            neg_int_reg <= 1'b0;
            ovf_int_reg <= 1'b0;
            bcd_reg     <= '0;
            neg_reg     <= 1'b0;
            ovf_reg     <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            mag_reg     <= mag_next;
            digits_reg  <= digits_next;
            cnt_reg     <= cnt_next;
            neg_int_reg <= neg_int_next;
            ovf_int_reg <= ovf_int_next;
            bcd_reg     <= bcd_next;
            neg_reg     <= neg_next;
            ovf_reg     <= ovf_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        mag_next     = mag_reg;
        digits_next  = digits_reg;
        cnt_next     = cnt_reg;
        neg_int_next = neg_int_reg;
        ovf_int_next = ovf_int_reg;
        bcd_next     = bcd_reg;
        neg_next     = neg_reg;
        ovf_next     = ovf_reg;
        done_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next   = SHIFT;
                    // Most-negative input negates to itself, which is correct read as unsigned.
                    mag_next     = (signed_mode && bin[WIDTH-1]) ? (~bin + BIN_ONE) : bin;
                    neg_int_next = signed_mode & bin[WIDTH-1];
                    digits_next  = '0;
                    ovf_int_next = 1'b0;
                    cnt_next     = CNT_INIT;
                end
            end
            SHIFT: begin
                digits_next  = shifted;
                ovf_int_next = ovf_int_reg | carry_out;
                mag_next     = {mag_reg[WIDTH-2:0], 1'b0};
                cnt_next     = cnt_reg - CNT_ONE;
                if (cnt_reg == CNT_ONE) begin
                    state_next = IDLE;
                    bcd_next   = shifted;
                    neg_next   = neg_int_reg;
                    ovf_next   = ovf_int_reg | carry_out;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg == SHIFT);
    assign done = done_reg;
    assign bcd  = bcd_reg;
    assign neg  = neg_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_bcd_serial_converter.sv
// Directed bench: three converter instances (8b/3d, 8b/2d, 16b/5d) sharing clock and reset.
module tb_bcd_serial_converter;

    logic        clk;
    logic        rst;
    logic [2:0]  start_v;
    logic [2:0]  sm_v;
    logic [15:0] bin_v [3];
    logic [2:0]  busy_v, done_v, neg_v, ovf_v;
    logic [11:0] bcd0;
    logic [7:0]  bcd1;
    logic [19:0] bcd2;
    logic [31:0] bcd_v [3];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bcd_serial_converter #(.WIDTH(8), .DIGITS(3)) u_w8d3 (
        .clk(clk), .rst(rst), .start(start_v[0]), .signed_mode(sm_v[0]), .bin(bin_v[0][7:0]),
        .busy(busy_v[0]), .done(done_v[0]), .bcd(bcd0), .neg(neg_v[0]), .ovf(ovf_v[0]));

    bcd_serial_converter #(.WIDTH(8), .DIGITS(2)) u_w8d2 (
        .clk(clk), .rst(rst), .start(start_v[1]), .signed_mode(sm_v[1]), .bin(bin_v[1][7:0]),
        .busy(busy_v[1]), .done(done_v[1]), .bcd(bcd1), .neg(neg_v[1]), .ovf(ovf_v[1]));

    bcd_serial_converter #(.WIDTH(16), .DIGITS(5)) u_w16d5 (
        .clk(clk), .rst(rst), .start(start_v[2]), .signed_mode(sm_v[2]), .bin(bin_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .bcd(bcd2), .neg(neg_v[2]), .ovf(ovf_v[2]));

    assign bcd_v[0] = {20'd0, bcd0};
    assign bcd_v[1] = {24'd0, bcd1};
    assign bcd_v[2] = {12'd0, bcd2};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start, wait (bounded) for done, then check latency, result and one-cycle done.
    task automatic run(input int u, input logic [15:0] b, input logic sm,
                       input logic [31:0] eb, input logic en, input logic eo,
                       input int lat, input string tag);
        int n;
        @(negedge clk);
        start_v[u] = 1'b1;
        sm_v[u]    = sm;
        bin_v[u]   = b;
        @(negedge clk);
        start_v[u] = 1'b0;
        chk({tag, " busy"}, 32'(busy_v[u]), 32'd1);
        n = 0;
        while (done_v[u] !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(lat));
        chk({tag, " bcd"}, bcd_v[u], eb);
        chk({tag, " neg"}, 32'(neg_v[u]), 32'(en));
        chk({tag, " ovf"}, 32'(ovf_v[u]), 32'(eo));
        chk({tag, " busy_end"}, 32'(busy_v[u]), 32'd0);
        @(negedge clk);
        chk({tag, " done_pulse"}, 32'(done_v[u]), 32'd0);
        $display("conv %s u=%0d bin=%0h sm=%0d -> bcd=%0h neg=%0d ovf=%0d lat=%0d",
                 tag, u, b, sm, bcd_v[u], neg_v[u], ovf_v[u], n);
    endtask

    initial begin
        int n;
        int dcount;
        rst     = 1'b1;
        start_v = '0;
        sm_v    = '0;
        for (int i = 0; i < 3; i++) bin_v[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst busy", 32'(busy_v[0]), 32'd0);
        chk("rst done", 32'(done_v[0]), 32'd0);
        chk("rst bcd", bcd_v[0], 32'h000);
        chk("rst neg", 32'(neg_v[0]), 32'd0);
        chk("rst ovf", 32'(ovf_v[0]), 32'd0);
        chk("rst bcd16", bcd_v[2], 32'h00000);

        run(0, 16'h00FF, 1'b0, 32'h255, 1'b0, 1'b0, 8, "u_ff");
        run(0, 16'h0000, 1'b0, 32'h000, 1'b0, 1'b0, 8, "u_00");
        run(0, 16'h0080, 1'b1, 32'h128, 1'b1, 1'b0, 8, "s_80");
        run(0, 16'h00FF, 1'b1, 32'h001, 1'b1, 1'b0, 8, "s_ff");
        run(0, 16'h007F, 1'b1, 32'h127, 1'b0, 1'b0, 8, "s_7f");
        run(0, 16'h0080, 1'b0, 32'h128, 1'b0, 1'b0, 8, "u_80");

        run(1, 16'h00C8, 1'b0, 32'h00, 1'b0, 1'b1, 8, "d2_200");
        run(1, 16'h0063, 1'b0, 32'h99, 1'b0, 1'b0, 8, "d2_99");

        run(2, 16'hFFFF, 1'b0, 32'h65535, 1'b0, 1'b0, 16, "w16_ffff");
        run(2, 16'h8000, 1'b1, 32'h32768, 1'b1, 1'b0, 16, "w16_s8000");

        // Handshake: extra starts and operand changes while busy must be ignored.
        @(negedge clk);
        start_v[0] = 1'b1; sm_v[0] = 1'b0; bin_v[0] = 16'h0055;
        @(negedge clk);
        bin_v[0] = 16'h00FF; sm_v[0] = 1'b1;
        dcount = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_v[0] === 1'b1) dcount++;
        end
        start_v[0] = 1'b0;
        chk("hs busy_mid", 32'(busy_v[0]), 32'd1);
        chk("hs hold_bcd", bcd_v[0], 32'h128);
        chk("hs early_done", 32'(dcount), 32'd0);
        n = 3;
        while (done_v[0] !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("hs latency", 32'(n), 32'd8);
        chk("hs bcd", bcd_v[0], 32'h085);
        chk("hs neg", 32'(neg_v[0]), 32'd0);
        $display("conv hs bin=55 -> bcd=%0h neg=%0d lat=%0d", bcd_v[0], neg_v[0], n);

        // Start issued in the done cycle is accepted.
        start_v[0] = 1'b1; sm_v[0] = 1'b1; bin_v[0] = 16'h00F4;
        @(negedge clk);
        start_v[0] = 1'b0;
        chk("b2b done_low", 32'(done_v[0]), 32'd0);
        chk("b2b busy", 32'(busy_v[0]), 32'd1);
        n = 0;
        while (done_v[0] !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("b2b latency", 32'(n), 32'd8);
        chk("b2b bcd", bcd_v[0], 32'h012);
        chk("b2b neg", 32'(neg_v[0]), 32'd1);
        $display("conv b2b bin=f4 signed -> bcd=%0h neg=%0d lat=%0d", bcd_v[0], neg_v[0], n);

        // Reset on cycle 4 of a conversion aborts it.
        @(negedge clk);
        start_v[0] = 1'b1; sm_v[0] = 1'b0; bin_v[0] = 16'h00FF;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", 32'(busy_v[0]), 32'd0);
        chk("abort bcd", bcd_v[0], 32'h000);
        chk("abort neg", 32'(neg_v[0]), 32'd0);
        chk("abort ovf", 32'(ovf_v[0]), 32'd0);
        dcount = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_v[0] === 1'b1) dcount++;
        end
        chk("abort no_done", 32'(dcount), 32'd0);
        $display("conv abort -> busy=%0d bcd=%0h dones=%0d", busy_v[0], bcd_v[0], dcount);

        run(0, 16'h002A, 1'b0, 32'h042, 1'b0, 1'b0, 8, "post_rst_2a");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
